// File: rtl/merger_run_collector.sv
// Root-of-tree sink for a 2-way merger: buffers the write-strobed stream, strips run
// terminators and re-emits runs on valid/ready. Optional key-order checker: RUN_ORDER_CHECK_EN.
module merger_run_collector #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_write,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  o_run_done,
    output logic [LEN_WIDTH-1:0]  o_run_len,
    output logic                  o_overflow,
    output logic                  o_order_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C      = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX_C = CW'(DEPTH - 2);

    typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_e;

    function automatic logic key_decrease(input logic [DATA_WIDTH-1:0] prev,
                                          input logic [DATA_WIDTH-1:0] nxt);
        return nxt[KEY_WIDTH-1:0] < prev[KEY_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] h_q, h_d, out_data_q, out_data_d;
    logic [LEN_WIDTH-1:0]  run_len_q, run_len_d, run_len_out_q, run_len_out_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  run_done_q, run_done_d, overflow_q, overflow_d;
    logic                  slot_free_s, pop_s, push_s, head_term_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Next-state logic: FIFO bookkeeping, holding-register FSM and output register
    always_comb begin
        slot_free_s   = ~out_valid_q | i_ready;
        pop_s         = (count_q != {CW{1'b0}}) & ((state_q == ST_EMPTY) | slot_free_s);
        push_s        = i_write & ((count_q != FULL_C) | pop_s);
        head_s        = mem_q[rd_ptr_q];
        head_term_s   = (head_s == {DATA_WIDTH{1'b0}});
        wr_ptr_d      = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        state_d       = state_q;
        h_d           = h_q;
        run_len_d     = run_len_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_valid_d   = slot_free_s ? 1'b0 : out_valid_q;
        run_done_d    = 1'b0;
        run_len_out_d = {LEN_WIDTH{1'b0}};
        overflow_d    = overflow_q | (i_write & (count_q == FULL_C) & ~pop_s);

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_s) begin
            case (state_q)
                ST_EMPTY: begin
                    if (head_term_s) begin
                        run_done_d = 1'b1;
                    end else begin
                        h_d       = head_s;
                        run_len_d = LEN_WIDTH'(1);
                        state_d   = ST_HELD;
                    end
                end
                ST_HELD: begin
                    out_data_d  = h_q;
                    out_valid_d = 1'b1;
                    if (head_term_s) begin
                        out_last_d    = 1'b1;
                        run_done_d    = 1'b1;
                        run_len_out_d = run_len_q;
                        state_d       = ST_EMPTY;
                    end else begin
                        out_last_d = 1'b0;
                        h_d        = head_s;
                        run_len_d  = (&run_len_q) ? run_len_q : run_len_q + LEN_WIDTH'(1);
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and output state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            state_q       <= ST_EMPTY;
            h_q           <= {DATA_WIDTH{1'b0}};
            run_len_q     <= {LEN_WIDTH{1'b0}};
            out_data_q    <= {DATA_WIDTH{1'b0}};
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            run_done_q    <= 1'b0;
            run_len_out_q <= {LEN_WIDTH{1'b0}};
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            h_q           <= h_d;
            run_len_q     <= run_len_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            run_done_q    <= run_done_d;
            run_len_out_q <= run_len_out_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

`ifdef RUN_ORDER_CHECK_EN
    logic order_err_q, order_err_d;

    // Sticky key-order violation flag, evaluated on every held pop of a real record
    always_comb begin
        order_err_d = order_err_q;
        if (pop_s && (state_q == ST_HELD) && !head_term_s && key_decrease(h_q, head_s)) begin
            order_err_d = 1'b1;
        end else begin
            order_err_d = order_err_q;
        end
    end

    // Order error register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

    // Ready is held low during reset so the merger never sees a stale grant
    assign o_ready    = i_rst_n & (count_q <= READY_MAX_C);
    assign o_data     = out_data_q;
    assign o_valid    = out_valid_q;
    assign o_last     = out_last_q;
    assign o_run_done = run_done_q;
    assign o_run_len  = run_len_out_q;
    assign o_overflow = overflow_q;
endmodule

// File: tb/tb_merger_run_collector.sv
// Randomized self-checking bench for merger_run_collector; expected output is the
// accepted write stream split into runs at each all-zero terminator.
module tb_merger_run_collector;
    localparam int DW = 128;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n, i_write, i_ready;
    logic [DW-1:0] i_data;
    logic          o_ready, o_valid, o_last, o_run_done, o_overflow, o_order_err;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_run_len;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_data_q[$];
    bit            exp_last_q[$];
    int            exp_len_q[$];
    int            cur_len = 0;
    int            mon_len;
    bit            allow = 1'b0;
    bit            rdy_last = 1'b0;
    bit            rand_rdy = 1'b0;
    logic [79:0]   key;

    always #5 clk = ~clk;

    merger_run_collector dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_write(i_write),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .i_ready(i_ready), .o_run_done(o_run_done), .o_run_len(o_run_len),
        .o_overflow(o_overflow), .o_order_err(o_order_err)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: records accumulate into the current run; a zero closes it.
    task automatic model_push(input logic [DW-1:0] d);
        if (d == '0) begin
            exp_len_q.push_back(cur_len);
            if (cur_len > 0) exp_last_q[exp_last_q.size()-1] = 1'b1;
            cur_len = 0;
        end else begin
            exp_data_q.push_back(d);
            exp_last_q.push_back(1'b0);
            if (cur_len < 65535) cur_len++;
        end
    endtask

    // The merger's view of ready is the value registered one edge earlier.
    task automatic tick();
        @(posedge clk);
        #1;
        allow    = rdy_last;
        rdy_last = o_ready;
        if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic write_rec(input logic [DW-1:0] d);
        int guard = 0;
        while (!allow && guard < 500) begin
            tick();
            guard++;
        end
        if (!allow) begin
            check_eq("write_timeout", 1'b0, 1'b1);
        end else begin
            i_write = 1'b1;
            i_data  = d;
            model_push(d);
            tick();
            i_write = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int g = 0;
        while ((exp_data_q.size() + exp_len_q.size()) != 0 && g < bound) begin
            tick();
            g++;
        end
        check_eq("drain_left", exp_data_q.size() + exp_len_q.size(), 0);
    endtask

    function automatic logic [DW-1:0] next_rec();
        key = key + 80'($urandom_range(1, 1000));
        return {16'($urandom), 32'($urandom), key};
    endfunction

    // Downstream monitor: every handshake and run report is matched against the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("spurious_out", 1'b1, 1'b0);
                end else begin
                    check_eq("out_data", o_data, exp_data_q.pop_front());
                    check_eq("out_last", o_last, exp_last_q.pop_front());
                end
            end
            if (o_run_done) begin
                if (exp_len_q.size() == 0) begin
                    check_eq("spurious_done", 1'b1, 1'b0);
                end else begin
                    mon_len = exp_len_q.pop_front();
                    check_eq("run_len", o_run_len, mon_len);
                    if (mon_len > 0) check_eq("done_with_last", {o_valid, o_last}, 2'b11);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_write = 1'b0; i_data = '0; i_ready = 1'b1;
        #1;
        check_eq("reset_ctrl", {o_ready, o_valid, o_last, o_run_done, o_overflow, o_order_err}, 6'b0);
        check_eq("reset_data", o_data, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_eq("ready_after_reset", o_ready, 1'b1);

        // Short run then two empty runs
        write_rec(128'd3); write_rec(128'd5); write_rec(128'd9); write_rec(128'd0);
        drain(50);
        write_rec(128'd0); write_rec(128'd0);
        drain(50);

        // 20 records against a stalled sink, honouring the registered ready
        i_ready = 1'b0;
        key = '0;
        fork
            begin
                for (int i = 0; i < 20; i++) write_rec(next_rec());
                write_rec(128'd0);
            end
            begin
                repeat (40) @(posedge clk);
                #2;
                check_eq("stall_ready_low", o_ready, 1'b0);
                check_eq("stall_no_overflow", o_overflow, 1'b0);
                i_ready = 1'b1;
            end
        join
        drain(100);
        check_eq("no_overflow", o_overflow, 1'b0);

        // Randomized runs with random gaps and random downstream backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 25; r++) begin
            key = '0;
            for (int n = $urandom_range(0, 6); n > 0; n--) begin
                if ($urandom_range(0, 3) == 0) tick();
                write_rec(next_rec());
            end
            write_rec(128'd0);
        end
        rand_rdy = 1'b0;
        i_ready  = 1'b1;
        drain(300);
        check_eq("order_err_random", o_order_err, 1'b0);

        // Writes ignoring ready into a stalled sink: output register, holding register
        // and the FIFO absorb 18 records, the 19th is dropped
        i_ready = 1'b0;
        key = '0;
        for (int i = 0; i < 20; i++) begin
            i_write = 1'b1;
            i_data  = next_rec();
            if (i < 18) model_push(i_data);
            tick();
            if (i == 17) check_eq("ovf_before_drop", o_overflow, 1'b0);
            if (i == 18) check_eq("ovf_after_drop", o_overflow, 1'b1);
        end
        i_write = 1'b0;
        i_ready = 1'b1;
        write_rec(128'd0);
        drain(100);
        check_eq("ovf_sticky", o_overflow, 1'b1);

        // Reset in the middle of an unterminated run
        write_rec(128'd1); write_rec(128'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrun_reset_ctrl", {o_ready, o_valid, o_last, o_run_done, o_overflow, o_order_err}, 6'b0);
        check_eq("midrun_reset_data", o_data, '0);
        check_eq("midrun_reset_len", o_run_len, '0);
        exp_data_q.delete(); exp_last_q.delete(); exp_len_q.delete(); cur_len = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        allow = 1'b0; rdy_last = 1'b0;
        write_rec(128'd8); write_rec(128'd0);
        drain(50);

        // Key decrease within a run: data flow unchanged, flag only with the checker built
        write_rec(128'd4); write_rec(128'd2); write_rec(128'd7); write_rec(128'd0);
        drain(50);
`ifdef RUN_ORDER_CHECK_EN
        check_eq("order_err", o_order_err, 1'b1);
`else
        check_eq("order_err", o_order_err, 1'b0);
`endif

        repeat (3) tick();
        check_eq("final_queues", exp_data_q.size() + exp_len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
